// File: rtl/cnn_layer_pkg.sv
// rtl/cnn_layer_pkg.sv - shared dimensions, FSM state type and upstream address helper
//
// Purpose: constants and types shared by the 11x11x64 -> 5x5x64 max-pool stage.
// Contents: layer dimensions, byte sizes of both feature maps, pool_state_t,
//           up_tap_addr() mapping (oy, ox, c, tap) to an upstream byte address.
package cnn_layer_pkg;

  localparam int IN_H      = 11;
  localparam int IN_W      = 11;
  localparam int CH        = 64;
  localparam int OUT_H     = 5;
  localparam int OUT_W     = 5;
  localparam int TAPS      = 4;
  localparam int UP_BYTES  = IN_H * IN_W * CH;    // 7744
  localparam int OUT_BYTES = OUT_H * OUT_W * CH;  // 1600
  localparam int OUT_WORDS = OUT_BYTES / 4;       // 400

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_UP,
    ST_WAIT_UP,
    ST_ISSUE,
    ST_SAMPLE,
    ST_WRITE,
    ST_FINISH
  } pool_state_t;

  // Tap index is dy*2+dx, so taps run (0,0),(0,1),(1,0),(1,1).
  function automatic logic [31:0] up_tap_addr(input logic [2:0] oy,
                                              input logic [2:0] ox,
                                              input logic [5:0] c,
                                              input logic [1:0] tap);
    logic [31:0] y;
    logic [31:0] x;
    y = {28'd0, oy, 1'b0} + {31'd0, tap[1]};
    x = {28'd0, ox, 1'b0} + {31'd0, tap[0]};
    return (y * 32'(IN_W) + x) * 32'(CH) + {26'd0, c};
  endfunction

endpackage

// File: rtl/pool2_output_buffer.sv
// rtl/pool2_output_buffer.sv - 400x32 simple dual-port RAM holding the pooled map
//
// Purpose: inferred block RAM; one byte-enabled write port, one registered read port.
// Ports:
//   clk      in  : clock
//   wr_en    in  : write strobe
//   wr_be    in  : byte enables, bit b covers wr_data[8b+7:8b]
//   wr_addr  in  : write word address
//   wr_data  in  : write word
//   rd_addr  in  : read word address (always enabled)
//   rd_data  out : read word, one cycle after rd_addr
module pool2_output_buffer
  import cnn_layer_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [3:0]  wr_be,
  input  logic [8:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [8:0]  rd_addr,
  output logic [31:0] rd_data
);

  logic [31:0] mem_q [0:OUT_WORDS-1];
  logic [31:0] rd_data_q;

  // No reset: contents are only meaningful after a complete sweep.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/maxpool2d_11x11x64_to_5x5x64.sv
// rtl/maxpool2d_11x11x64_to_5x5x64.sv - 2x2 stride-2 signed max-pool, 11x11x64 -> 5x5x64
//
// Purpose: triggers the upstream conv layer, waits for its done, pools its output
//          into an internal buffer and serves that buffer through a byte read port.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : one-cycle run request (honoured in IDLE/FINISH)
//   read_addr/read_data  : byte read port into the pooled 5x5x64 map
//   done                 : pooled map complete and readable
//   up_start             : one-cycle start pulse to the upstream layer
//   up_read_addr/_data   : byte read port of the upstream 11x11x64 map
//   up_done              : upstream result valid
module maxpool2d_11x11x64_to_5x5x64
  import cnn_layer_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] read_addr,
  output logic [7:0]  read_data,
  output logic        done,
  output logic        up_start,
  output logic [31:0] up_read_addr,
  input  logic [7:0]  up_read_data,
  input  logic        up_done
);

  pool_state_t       state_q;
  logic [2:0]        oy_q, ox_q;
  logic [5:0]        c_q;
  logic [1:0]        tap_q;
  logic signed [7:0] max_q;
  logic [31:0]       pack_q;
  logic              done_q;
  logic              up_start_q;
  logic [31:0]       up_read_addr_q;

  logic [2:0]        oy_d, ox_d;
  logic [5:0]        c_d;
  logic [31:0]       pack_d;
  logic              last_out;
  logic signed [7:0] sample;

  logic              wr_en;
  logic [4:0]        pix_idx;
  logic [8:0]        wr_addr;
  logic [8:0]        rd_addr;
  logic [31:0]       rd_word;

  assign sample = up_read_data;

  // Next output position (c innermost, then ox, then oy) and lane merge of the
  // finished maximum; only consumed in WRITE.
  always_comb begin
    c_d  = c_q + 6'd1;
    ox_d = ox_q;
    oy_d = oy_q;
    if (c_q == 6'(CH - 1)) begin
      if (ox_q == 3'(OUT_W - 1)) begin
        ox_d = 3'd0;
        oy_d = oy_q + 3'd1;
      end else begin
        ox_d = ox_q + 3'd1;
      end
    end
    last_out = (oy_q == 3'(OUT_H - 1)) && (ox_q == 3'(OUT_W - 1)) && (c_q == 6'(CH - 1));

    pack_d = pack_q;
    case (c_q[1:0])
      2'd0:    pack_d[31:24] = max_q;
      2'd1:    pack_d[23:16] = max_q;
      2'd2:    pack_d[15:8]  = max_q;
      default: pack_d[7:0]   = max_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      oy_q           <= '0;
      ox_q           <= '0;
      c_q            <= '0;
      tap_q          <= '0;
      max_q          <= '0;
      pack_q         <= '0;
      done_q         <= 1'b0;
      up_start_q     <= 1'b0;
      up_read_addr_q <= '0;
    end else begin
      up_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            up_start_q <= 1'b1;
            state_q    <= ST_START_UP;
          end
        end
        ST_START_UP: begin
          oy_q    <= '0;
          ox_q    <= '0;
          c_q     <= '0;
          tap_q   <= '0;
          pack_q  <= '0;
          state_q <= ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (up_done) begin
            up_read_addr_q <= up_tap_addr(oy_q, ox_q, c_q, 2'd0);
            state_q        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (tap_q == 2'd0 || sample > max_q) begin
            max_q <= sample;
          end
          if (tap_q == 2'(TAPS - 1)) begin
            state_q <= ST_WRITE;
          end else begin
            tap_q          <= tap_q + 2'd1;
            up_read_addr_q <= up_tap_addr(oy_q, ox_q, c_q, tap_q + 2'd1);
            state_q        <= ST_ISSUE;
          end
        end
        ST_WRITE: begin
          pack_q <= pack_d;
          tap_q  <= '0;
          c_q    <= c_d;
          ox_q   <= ox_d;
          oy_q   <= oy_d;
          if (last_out) begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            up_read_addr_q <= up_tap_addr(oy_d, ox_d, c_d, 2'd0);
            state_q        <= ST_ISSUE;
          end
        end
        ST_FINISH: begin
          if (start) begin
            done_q     <= 1'b0;
            up_start_q <= 1'b1;
            state_q    <= ST_START_UP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Word index = out_idx>>2 = pixel*16 + c[5:2], since 64 channels fill 16 words.
  assign pix_idx = ({2'd0, oy_q} * 5'(OUT_W)) + {2'd0, ox_q};
  assign wr_addr = {pix_idx, c_q[5:2]};
  assign wr_en   = (state_q == ST_WRITE) && (c_q[1:0] == 2'd3);

  // Out-of-range byte addresses land on an unused word; their data is undefined.
  assign rd_addr = (read_addr < 32'(OUT_BYTES)) ? read_addr[10:2] : 9'h1FF;

  pool2_output_buffer u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_be   (4'hF),
    .wr_addr (wr_addr),
    .wr_data (pack_d),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  // Lane 0 is the most significant byte.
  always_comb begin
    case (read_addr[1:0])
      2'd0:    read_data = rd_word[31:24];
      2'd1:    read_data = rd_word[23:16];
      2'd2:    read_data = rd_word[15:8];
      default: read_data = rd_word[7:0];
    endcase
  end

  assign done         = done_q;
  assign up_start     = up_start_q;
  assign up_read_addr = up_read_addr_q;

endmodule

// File: tb/tb_maxpool2d_11x11x64_to_5x5x64.sv
// tb/tb_maxpool2d_11x11x64_to_5x5x64.sv - self-checking bench for the 11x11x64 -> 5x5x64 max-pool
module tb_maxpool2d_11x11x64_to_5x5x64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] read_addr = 32'd0;
  logic [7:0]  read_data;
  logic        done;
  logic        up_start;
  logic [31:0] up_read_addr;
  logic [7:0]  up_read_data = 8'd0;
  logic        up_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] up_mem [0:7743];
  int  up_cnt = 0;
  bit  armed = 1'b0;
  int  up_start_cnt = 0;
  int  bad_cnt = 0;

  maxpool2d_11x11x64_to_5x5x64 dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .done         (done),
    .up_start     (up_start),
    .up_read_addr (up_read_addr),
    .up_read_data (up_read_data),
    .up_done      (up_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream conv layer: 1-cycle read latency, done raised so that it is first
  // sampled 50 edges after the edge that accepted start.
  always @(posedge clk) begin
    up_read_data <= (up_read_addr < 32'd7744) ? up_mem[up_read_addr] : 8'hxx;
    if (up_start) begin
      up_cnt       <= 0;
      up_done      <= 1'b0;
      armed        <= 1'b1;
      up_start_cnt <= up_start_cnt + 1;
    end else if (armed) begin
      up_cnt <= up_cnt + 1;
      if (up_cnt == 47) begin
        up_done <= 1'b1;
        armed   <= 1'b0;
      end
    end
    if (up_read_addr >= 32'd7744 || (up_read_addr / 64) / 11 == 10 || (up_read_addr / 64) % 11 == 10)
      bad_cnt <= bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Golden value straight from the pooling definition and both byte layouts.
  function automatic logic [7:0] gold(input int a);
    int pos, c, oy, ox;
    logic signed [7:0] m, v;
    pos = a / 64;
    c   = a % 64;
    oy  = pos / 5;
    ox  = pos % 5;
    m   = up_mem[((2 * oy) * 11 + 2 * ox) * 64 + c];
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = up_mem[((2 * oy + dy) * 11 + 2 * ox + dx) * 64 + c];
        if (v > m) m = v;
      end
    return m;
  endfunction

  // Starts a run at a negedge and waits for done; done must be seen after the
  // edge 14450 edges past the one that accepted start (i.e. in cycle T+14451).
  task automatic run_pool(input string tag, input bit busy_start);
    int t0, n_up, waited;
    bit seen;
    n_up = up_start_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check({tag, " up_start_pulse"}, {31'd0, up_start}, 32'd1);
    check({tag, " done_low_after_start"}, {31'd0, done}, 32'd0);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 20000) begin
      @(negedge clk);
      waited++;
      if (busy_start) start = (waited == 3000);
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, 32'(cyc - t0), 32'd14450);
    check({tag, " up_start_count"}, 32'(up_start_cnt - n_up), 32'd1);
  endtask

  // n == 0: full ordered sweep of all 1600 bytes; otherwise n random bytes.
  task automatic read_check(input string tag, input int n);
    int a, total;
    total = (n == 0) ? 1600 : n;
    for (int i = 0; i < total; i++) begin
      a = (n == 0) ? i : int'($urandom_range(0, 1599));
      read_addr = 32'(a);
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, a), {24'd0, read_data}, {24'd0, gold(a)});
    end
  endtask

  initial begin
    int bad0;

    repeat (3) @(negedge clk);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset up_start", {31'd0, up_start}, 32'd0);
    check("reset up_read_addr", up_read_addr, 32'd0);
    resetn = 1'b1;

    // Ramp: full sweep, also covers lane order at addresses 0..3.
    for (int a = 0; a < 7744; a++) up_mem[a] = 8'((a * 7) & 255);
    run_pool("ramp", 1'b0);
    read_check("ramp", 0);

    // All -128 with a start pulse mid-sweep that must be ignored.
    for (int a = 0; a < 7744; a++) up_mem[a] = 8'h80;
    run_pool("neg128_busy", 1'b1);
    read_check("neg128", 200);

    // All +127 except tap (1,1) = -128: max stays +127.
    for (int a = 0; a < 7744; a++) up_mem[a] = 8'h7F;
    for (int c = 0; c < 64; c++) up_mem[(1 * 11 + 1) * 64 + c] = 8'h80;
    run_pool("pos127", 1'b0);
    read_check("pos127", 200);

    // Row 10 / column 10 hold +127, everything else 0: never read.
    for (int a = 0; a < 7744; a++)
      up_mem[a] = ((a / 64) / 11 == 10 || (a / 64) % 11 == 10) ? 8'h7F : 8'h00;
    bad0 = bad_cnt;
    run_pool("discard", 1'b0);
    check("discard edge_reads", 32'(bad_cnt - bad0), 32'd0);
    read_check("discard", 200);

    // Random data, reset mid-run, then a clean restart.
    for (int a = 0; a < 7744; a++) up_mem[a] = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5000) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset up_start", {31'd0, up_start}, 32'd0);
    check("midreset up_read_addr", up_read_addr, 32'd0);
    @(negedge clk);
    check("midreset held up_start", {31'd0, up_start}, 32'd0);
    resetn = 1'b1;
    run_pool("restart", 1'b0);
    read_check("restart", 0);

    check("no_edge_or_oob_reads", 32'(bad_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool2d_11x11x64_to_5x5x64.md
# maxpool2d_11x11x64_to_5x5x64

Second pooling stage of the MNIST CNN datapath. It triggers the upstream 11×11×64 conv layer, waits for that layer's `done`, and reads its byte-addressed output port. It computes a 2×2 stride-2 signed max-pool into an internal 5×5×64 buffer, then exposes the same `start`/`read_addr`/`read_data`/`done` interface to the next layer. It is the reader side of the conv layer's output-port protocol.

## Interface
- `IN_H`, `IN_W` = 11, 11: upstream spatial size.
- `CH` = 64: channel count.
- `OUT_H`, `OUT_W` = 5, 5: pooled size, floor(IN/2).
- `clk` in 1: single clock, all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a run when in IDLE or FINISH.
- `read_addr` in 32: byte address into the pooled buffer, 0..1599.
- `read_data` out 8: signed pooled byte at `read_addr`.
- `done` out 1: high while the buffer holds a complete result.
- `up_start` out 1: one-cycle start pulse to the upstream conv layer.
- `up_read_addr` out 32: byte address into the upstream output, 0..7743.
- `up_read_data` in 8: upstream signed byte.
- `up_done` in 1: upstream result valid; level signal.

## Operation
- **Upstream layout:** byte `((y*11 + x)*64 + c)`.
- **Own layout:** byte `((oy*5 + ox)*64 + c)`.
- **Word packing:** stored in 32-bit words at `addr>>2`. Lane `addr[1:0]`=0 maps to bits 31:24, 1 to 23:16, 2 to 15:8, 3 to 7:0.
- **Pooling function:** `out[oy][ox][c]` = signed max of the upstream taps (2oy+dy, 2ox+dx, c), dy,dx ∈ {0,1}. Row 10 and column 10 are never read.
- **Loop order:** c innermost, then ox, then oy. Taps in order (0,0), (0,1), (1,0), (1,1).
- **FSM states:** IDLE, START_UP, WAIT_UP, ISSUE, SAMPLE, WRITE, FINISH.
  - IDLE: `start` → START_UP.
  - START_UP: `up_start`=1 for exactly this cycle; clear counters → WAIT_UP.
  - WAIT_UP: stay until `up_done`=1 → ISSUE.
  - ISSUE: drive `up_read_addr` for the current tap → SAMPLE.
  - SAMPLE: hold `up_read_addr` unchanged. Register `up_read_data`. For tap 0 the accumulator is loaded directly; otherwise `max <= (data > max) ? data : max`, signed 8-bit compare. Not last tap → ISSUE; last tap → WRITE.
  - WRITE: merge the max into lane `c[1:0]` of the pack register. When `c[1:0]`==3, write the full word to buffer word `out_idx>>2` with all byte enables. Advance c/ox/oy. Last output (oy=4, ox=4, c=63) → FINISH; else → ISSUE.
  - FINISH: `done`=1. `start` → START_UP with `done` cleared that same cycle.
- `start` in START_UP..WRITE is ignored.
- `up_done` dropping after WAIT_UP is ignored; the upstream is assumed static once done.
- Accumulator is 8-bit signed; no widening and no saturation needed.

## Timing
- **Reset values:** `done`=0, `up_start`=0, `up_read_addr`=0, state=IDLE, counters=0, pack=0. `read_data` follows the buffer; contents are not reset.
- **Upstream read:** address is presented in ISSUE and held through SAMPLE; data is sampled at the end of SAMPLE. This covers the one-cycle upstream BRAM latency plus the combinational lane mux.
- **Per output:** 9 cycles (4×ISSUE/SAMPLE plus WRITE). Full sweep is 1600×9 = 14400 cycles.
- **Total latency:** `start` high at edge T → `up_start` high in cycle T+1. If `up_done` is first seen in WAIT_UP at cycle U, `done` rises at cycle U+1+14400.
- **Own read port:** one-cycle latency. `read_addr` sampled at edge N gives `read_data` valid in cycle N+1 while `read_addr` is held. The lane mux is combinational on the current `read_addr[1:0]`.
- **Read validity:** reads are legal any time but return valid data only while `done`=1.
- **Port conflict:** the buffer is simple dual-port. The write port is used only in WRITE; the read port is always enabled. No write/read hazard exists after `done`.
- **Async reset mid-run:** every output returns to its reset value immediately, and `up_start` never glitches high. The next `start` restarts cleanly and re-pulses the upstream.
- **Address bounds:** `read_addr` above 1599 returns undefined data; no error flag.

## Structure
- Shared package `cnn_layer_pkg` holds:
  - the dimension localparams (11, 5, 64, 4 taps);
  - the byte-size constants 7744 and 1600;
  - `pool_state_t` enum.
- Sub-module `pool2_output_buffer` is a 400×32 simple dual-port RAM with a byte-enable write port and a registered read port. It is inferred BRAM, swappable for a block-design wrapper.

## Test plan
- **Ramp:** upstream model returns `(addr*7)&0xFF` with 1-cycle latency and `up_done` 50 cycles after `up_start` → all 1600 outputs match the golden signed max; `done` rises exactly 14451 cycles after `start`.
- **Extremes:** all upstream bytes 0x80 (-128) → every output 0x80. All bytes 0x7F except (1,1,c)=0x80 → outputs 0x7F.
- **Discarded edge:** row 10 and column 10 hold 0x7F, all else 0x00 → all outputs 0x00; `up_read_addr` never hits y=10 or x=10.
- **Lane order:** after `done`, read byte addresses 0,1,2,3 of word 0 → channels 0..3 of (0,0) in that order.
- **Busy start:** `start` pulsed mid-sweep → ignored, result unchanged.
- **Reset and restart:** `resetn` low at cycle 5000 → `done`=0 and `up_start`=0 immediately; a new `start` produces one `up_start` pulse and correct results. `start` in FINISH drops `done` and reruns.
